// File: rtl/o_buffer_acc_if.sv
// ---------------------------------------------------------------------------
// o_buffer_acc_if
//   Bundles the configuration, input-beat stream, output-row stream and status
//   signals of the output accumulation buffer.
//
//   cfg_start / cfg_k_tiles / cfg_n_rows : job start pulse and job shape
//   in_valid / in_ready / in_data        : partial-sum rows from the array
//   out_valid / out_ready / out_data     : accumulated rows to the output path
//   busy / done                          : job status
//
//   master : the side that issues jobs, feeds beats and consumes rows
//   slave  : the accumulation buffer itself
// ---------------------------------------------------------------------------
interface o_buffer_acc_if #(
  parameter int LANES  = 8,
  parameter int PSUM_W = 32
);
  logic                    cfg_start;
  logic [7:0]              cfg_k_tiles;
  logic [4:0]              cfg_n_rows;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*PSUM_W-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*PSUM_W-1:0] out_data;
  logic                    busy;
  logic                    done;

  modport master (
    output cfg_start, cfg_k_tiles, cfg_n_rows, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, done
  );

  modport slave (
    input  cfg_start, cfg_k_tiles, cfg_n_rows, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, done
  );
endinterface

// File: rtl/o_buffer_acc.sv
// ---------------------------------------------------------------------------
// o_buffer_acc
//   Output accumulation buffer downstream of the matrix array. Accepts one row
//   of LANES partial sums per beat, accumulates k_tiles passes of n_rows rows
//   into a DEPTH-entry register file, then drains the finished rows over a
//   valid/ready handshake and pulses done.
//
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : o_buffer_acc_if.slave (config, input beats, output rows, status)
//
//   Sequence: IDLE -> ACC -> DRAIN -> DONE -> IDLE. All outputs are registered.
// ---------------------------------------------------------------------------
module o_buffer_acc #(
  parameter int LANES  = 8,
  parameter int PSUM_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic           clk,
  input  logic           rst,
  o_buffer_acc_if.slave  bus
);

  localparam int ROW_W = LANES * PSUM_W;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state;
  logic [7:0]       k_last;     // cfg_k_tiles - 1, latched at start
  logic [7:0]       pass;
  logic [IDX_W-1:0] n_last;     // cfg_n_rows - 1, latched at start
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [ROW_W-1:0] mem [DEPTH];
  logic [ROW_W-1:0] acc_row;
  logic             beat;
  logic             cfg_ok;

  // in_ready is high only in ACC, so a beat can never land outside ACC.
  assign beat   = bus.in_valid && bus.in_ready;
  assign cfg_ok = (bus.cfg_k_tiles != 8'd0) && (bus.cfg_n_rows != 5'd0) &&
                  (32'(bus.cfg_n_rows) <= DEPTH);

  // Value written for the current beat: pass 0 overwrites stale contents,
  // later passes add lane-wise with natural modulo-2^PSUM_W wrap.
  always_comb begin
    // NOTE: default assignment first so every path drives acc_row and no latch is inferred.
    acc_row = bus.in_data;
    if (pass != 8'd0) begin
      for (int i = 0; i < LANES; i++) begin
        acc_row[i*PSUM_W +: PSUM_W] = mem[wr_idx][i*PSUM_W +: PSUM_W] +
                                      bus.in_data[i*PSUM_W +: PSUM_W];
      end
    end
  end

  // NOTE: the register file has no reset; pass 0 of every job overwrites each
  // entry before it is read, so clearing it would only cost a reset tree.
  always_ff @(posedge clk) begin
    if (!rst && beat) begin
      mem[wr_idx] <= acc_row;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      pass          <= 8'd0;
      wr_idx        <= '0;
      rd_idx        <= '0;
      k_last        <= 8'd0;
      n_last        <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.cfg_start && cfg_ok) begin
            k_last       <= bus.cfg_k_tiles - 8'd1;
            n_last       <= IDX_W'(bus.cfg_n_rows - 5'd1);
            state        <= S_ACC;
            bus.in_ready <= 1'b1;
            bus.busy     <= 1'b1;
          end
        end

        S_ACC: begin
          if (beat) begin
            if (wr_idx == n_last) begin
              wr_idx <= '0;
              pass   <= pass + 8'd1;
              if (pass == k_last) begin
                state         <= S_DRAIN;
                bus.in_ready  <= 1'b0;
                bus.out_valid <= 1'b1;
                // Row 0 is being written on this very edge when n_rows == 1,
                // so forward the fresh sum instead of the stale entry.
                bus.out_data  <= (n_last == '0) ? acc_row : mem[0];
              end
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end

        S_DRAIN: begin
          if (bus.out_ready) begin
            if (rd_idx == n_last) begin
              state         <= S_DONE;
              bus.out_valid <= 1'b0;
              bus.out_data  <= '0;
              bus.done      <= 1'b1;
            end else begin
              rd_idx       <= rd_idx + 1'b1;
              bus.out_data <= mem[IDX_W'(rd_idx + 1'b1)];
            end
          end
        end

        S_DONE: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
          pass     <= 8'd0;
          wr_idx   <= '0;
          rd_idx   <= '0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
